spi_slave: RTL and testbench

SPI slave endpoint that pairs with the team's `spi_master`: it receives serial data on `mosi` and returns a parallel-loaded word on `miso` within one chip-select frame. All logic runs on the system `clk`. `sclk`, `cs` and `mosi` are synchronised and edge-detected in the `clk` domain. Bit order, edge usage and frame length match the master:
- MSB first.
- `mosi` changes after an `sclk` rising edge.
- `miso` is sampled by the master on the `sclk` falling edge.
- Frames are `SPI_TRF_BIT` bits long.

---
 rtl/spi_slave.sv | 157 +++++++++++++++
 tb/tb_spi_slave.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave endpoint: MSB-first, master samples miso on sclk fall, slave samples mosi on sclk fall.
// All pins are resynchronised into clk; one frame is SPI_TRF_BIT bits framed by an active-low cs.
module spi_slave #(
    parameter int SPI_TRF_BIT = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sclk,
    input  logic                   cs,
    input  logic                   mosi,
    output logic                   miso,
    input  logic [SPI_TRF_BIT-1:0] tx_data,
    input  logic                   tx_load,
    output logic                   tx_ready,
    output logic [SPI_TRF_BIT-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   underrun
);

    localparam int CW = $clog2(SPI_TRF_BIT + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(SPI_TRF_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(SPI_TRF_BIT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    logic sclk_meta_reg, sclk_sync_reg, sclk_prev_reg;
    logic cs_meta_reg, cs_sync_reg, cs_prev_reg;
    logic mosi_meta_reg, mosi_sync_reg;

    state_t                 state_reg;
    logic [SPI_TRF_BIT-1:0] tx_buf_reg;
    logic                   tx_pend_reg;
    logic [SPI_TRF_BIT-1:0] tx_shift_reg;
    logic [SPI_TRF_BIT-1:0] rx_shift_reg;
    logic [CW-1:0]          tx_cnt_reg;
    logic [CW-1:0]          rx_cnt_reg;
    logic                   miso_reg;
    logic [SPI_TRF_BIT-1:0] rx_data_reg;
    logic                   rx_valid_reg;
    logic                   frame_err_reg;
    logic                   underrun_reg;

    logic                   sclk_pos, sclk_neg, cs_fall, cs_rise;
    logic [SPI_TRF_BIT-1:0] rx_next;

    // cs synchroniser resets high so a released reset never looks like a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_reg <= 1'b0;
            sclk_sync_reg <= 1'b0;
            sclk_prev_reg <= 1'b0;
            cs_meta_reg   <= 1'b1;
            cs_sync_reg   <= 1'b1;
            cs_prev_reg   <= 1'b1;
            mosi_meta_reg <= 1'b0;
            mosi_sync_reg <= 1'b0;
        end else begin
            sclk_meta_reg <= sclk;
            sclk_sync_reg <= sclk_meta_reg;
            sclk_prev_reg <= sclk_sync_reg;
            cs_meta_reg   <= cs;
            cs_sync_reg   <= cs_meta_reg;
            cs_prev_reg   <= cs_sync_reg;
            mosi_meta_reg <= mosi;
            mosi_sync_reg <= mosi_meta_reg;
        end
    end

    assign sclk_pos = ~sclk_prev_reg & sclk_sync_reg;
    assign sclk_neg = sclk_prev_reg & ~sclk_sync_reg;
    assign cs_fall  = cs_prev_reg & ~cs_sync_reg;
    assign cs_rise  = ~cs_prev_reg & cs_sync_reg;
    assign rx_next  = {rx_shift_reg[SPI_TRF_BIT-2:0], mosi_sync_reg};

    assign busy     = (state_reg != IDLE);
    assign tx_ready = ~tx_pend_reg & ~busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            tx_buf_reg    <= '0;
            tx_pend_reg   <= 1'b0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            tx_cnt_reg    <= '0;
            rx_cnt_reg    <= '0;
            miso_reg      <= 1'b0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            underrun_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    miso_reg   <= 1'b0;
                    tx_cnt_reg <= '0;
                    rx_cnt_reg <= '0;
                    if (cs_fall) begin
                        tx_shift_reg <= tx_pend_reg ? tx_buf_reg : '0;
                        underrun_reg <= ~tx_pend_reg;
                        tx_pend_reg  <= 1'b0;
                        state_reg    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // an abort wins even against the final sample in the same cycle
                    if (cs_rise) begin
                        frame_err_reg <= 1'b1;
                        miso_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (sclk_pos) begin
                        if (tx_cnt_reg < CNT_FULL) begin
                            miso_reg     <= tx_shift_reg[SPI_TRF_BIT-1];
                            tx_shift_reg <= {tx_shift_reg[SPI_TRF_BIT-2:0], 1'b0};
                            tx_cnt_reg   <= tx_cnt_reg + CW'(1);
                        end else begin
                            miso_reg <= 1'b0;
                        end
                    end else if (sclk_neg) begin
                        rx_shift_reg <= rx_next;
                        rx_cnt_reg   <= rx_cnt_reg + CW'(1);
                        if (rx_cnt_reg == CNT_LAST) begin
                            rx_data_reg  <= rx_next;
                            rx_valid_reg <= 1'b1;
                            miso_reg     <= 1'b0;
                            state_reg    <= DONE;
                        end
                    end
                end
                DONE: begin
                    miso_reg <= 1'b0;
                    if (cs_rise) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // placed last so a load coinciding with a frame start is kept for the next frame
            if (tx_load && tx_ready) begin
                tx_buf_reg  <= tx_data;
                tx_pend_reg <= 1'b1;
            end
        end
    end

    assign miso      = miso_reg;
    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign underrun  = underrun_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: acts as the SPI master and checks frames against a word-level model
// (pending TX word, last good RX word, expected pulse counts per frame).
module tb_spi_slave;

    localparam int N    = 12;
    localparam int HALF = 6;

    logic         clk = 1'b0;
    logic         rst_n, sclk, cs, mosi, miso;
    logic [N-1:0] tx_data, rx_data;
    logic         tx_load, tx_ready, rx_valid, busy, frame_err, underrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int rxv_cnt = 0, fe_cnt = 0, ur_cnt = 0;

    logic         m_pend = 1'b0;
    logic [N-1:0] m_buf  = '0;
    logic [N-1:0] exp_rx = '0;

    spi_slave #(.SPI_TRF_BIT(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .frame_err(frame_err),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // high-cycle counts: one count per frame also proves each pulse is one cycle wide
    always @(posedge clk) begin
        if (rx_valid === 1'b1)  rxv_cnt <= rxv_cnt + 1;
        if (frame_err === 1'b1) fe_cnt  <= fe_cnt + 1;
        if (underrun === 1'b1)  ur_cnt  <= ur_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [N-1:0] w);
        logic acc;
        acc = !m_pend;
        check("tx_ready_before_load", 32'(tx_ready), 32'(acc));
        tx_data = w;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        if (acc) begin
            m_buf  = w;
            m_pend = 1'b1;
        end
        $display("load    word=%03h accepted=%0d", w, acc);
    endtask

    // nclk sclk cycles; fewer than N means the frame is aborted by cs rising
    task automatic run_frame(input logic [N-1:0] mosi_w, input int nclk, input bit mid_load,
                             input string tag);
        logic [N-1:0] miso_w, exp_miso, mask;
        logic         exp_ur, full;
        int           rv0, fe0, ur0;
        exp_miso = m_pend ? m_buf : '0;
        exp_ur   = !m_pend;
        m_pend   = 1'b0;
        full     = (nclk >= N);
        for (int i = 0; i < N; i++) mask[N-1-i] = (i < nclk);
        rv0 = rxv_cnt; fe0 = fe_cnt; ur0 = ur_cnt;
        miso_w = '0;
        check({tag, "_miso_idle"}, 32'(miso), 32'(0));
        cs = 1'b0;
        tick(6);
        check({tag, "_busy_start"}, 32'(busy), 32'(1));
        for (int i = 0; i < nclk; i++) begin
            sclk = 1'b1;
            tick(1);
            mosi = (i < N) ? mosi_w[N-1-i] : 1'b0;
            tick(HALF - 1);
            if (i < N) miso_w[N-1-i] = miso;
            else check({tag, "_miso_done"}, 32'(miso), 32'(0));
            sclk = 1'b0;
            if (mid_load && i == 3) begin
                check({tag, "_tx_ready_busy"}, 32'(tx_ready), 32'(0));
                tx_data = 12'h123;
                tx_load = 1'b1;
                tick(1);
                tx_load = 1'b0;
                tick(HALF - 1);
            end else begin
                tick(HALF);
            end
        end
        check({tag, "_busy_before_cs"}, 32'(busy), 32'(1));
        cs   = 1'b1;
        mosi = 1'b0;
        tick(4);
        check({tag, "_busy_after_cs"}, 32'(busy), 32'(0));
        tick(1);
        if (full) exp_rx = mosi_w;
        check({tag, "_miso_word"}, 32'(miso_w & mask), 32'(exp_miso & mask));
        check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
        check({tag, "_rx_valid_cnt"}, 32'(rxv_cnt - rv0), 32'(full));
        check({tag, "_frame_err_cnt"}, 32'(fe_cnt - fe0), 32'(!full));
        check({tag, "_underrun_cnt"}, 32'(ur_cnt - ur0), 32'(exp_ur));
        check({tag, "_tx_ready_idle"}, 32'(tx_ready), 32'(!m_pend));
        $display("frame   %s nclk=%0d mosi=%03h miso=%03h rx_data=%03h", tag, nclk, mosi_w,
                 miso_w, rx_data);
    endtask

    initial begin
        logic [N-1:0] w;
        int           nc;
        rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_load = 1'b0; tx_data = '0;
        tick(3);
        check("rst_miso", 32'(miso), 32'(0));
        check("rst_rx_data", 32'(rx_data), 32'(0));
        check("rst_rx_valid", 32'(rx_valid), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        check("rst_underrun", 32'(underrun), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_tx_ready", 32'(tx_ready), 32'(1));
        $display("reset   initial");
        rst_n = 1'b1;
        tick(4);

        load_word(12'hA5C);
        load_word(12'h777);
        run_frame(12'h3F1, N, 1'b0, "full_duplex");

        run_frame(N'($urandom_range(0, (1 << N) - 1)), 5, 1'b0, "abort");
        run_frame(N'($urandom_range(0, (1 << N) - 1)), N, 1'b1, "underrun");

        load_word(12'h5E7);
        run_frame(12'h001, N + 1, 1'b0, "extra_clk_a");
        run_frame(12'hFFF, N + 1, 1'b0, "extra_clk_b");

        // reset in the middle of a frame, with no clock edge before the outputs are checked
        load_word(N'($urandom_range(0, (1 << N) - 1)));
        cs = 1'b0;
        tick(6);
        for (int i = 0; i < 6; i++) begin
            sclk = 1'b1; tick(1); mosi = i[0]; tick(HALF - 1);
            sclk = 1'b0; tick(HALF);
        end
        rst_n = 1'b0;
        #1;
        m_pend = 1'b0;
        exp_rx = '0;
        check("midrst_miso", 32'(miso), 32'(0));
        check("midrst_rx_data", 32'(rx_data), 32'(0));
        check("midrst_rx_valid", 32'(rx_valid), 32'(0));
        check("midrst_frame_err", 32'(frame_err), 32'(0));
        check("midrst_underrun", 32'(underrun), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_tx_ready", 32'(tx_ready), 32'(1));
        $display("reset   mid-frame");
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        run_frame(12'h5A5, N, 1'b0, "after_reset");

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) load_word(N'($urandom_range(0, (1 << N) - 1)));
            nc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1))
                                             : N + int'($urandom_range(0, 1));
            w = N'($urandom_range(0, (1 << N) - 1));
            run_frame(w, nc, 1'b0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
